// File: rtl/ch_est_cntrl_unit.sv
// NB-IoT channel-estimation control unit: two-pass NRS sequencing plus interpolation select sequencer.
// Optional macro CH_EST_INTERP_DONE_EN adds the interp_done pulse output.
module ch_est_cntrl_unit #(
  parameter int NRS_ADDR           = 4,
  parameter int OUT_SEL_SEQ_LENGTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                demap_ready,
  input  logic                NRS_gen_ready,
  input  logic [2:0]          v_shift,
  output logic [3:0]          col,
  output logic [1:0]          nrs_index_addr,
  output logic                demap_read,
  output logic [NRS_ADDR-1:0] rd_addr_nrs,
  output logic                valid_eqlz,
  output logic [1:0]          addr_mem,
  output logic                mult_mem_en,
  output logic                avg_mem_en,
  output logic                en_reg_E,
  output logic                en_reg_2E,
  output logic                en_reg_5E,
  output logic [2:0]          s1a,
  output logic [2:0]          s1b,
  output logic [2:0]          s2a,
  output logic [2:0]          s2b,
  output logic [1:0]          s_h1,
  output logic [1:0]          s_h2,
  output logic                s_est
`ifdef CH_EST_INTERP_DONE_EN
  ,
  output logic                interp_done
`endif
);

  localparam int STEP_W = $clog2(OUT_SEL_SEQ_LENGTH);

  typedef enum logic [1:0] {IDLE, MULT_STORE, MULT_ADD} state_t;

  // Select word layout: {s1a, s1b, s2a, s2b, s_h1, s_h2}
  localparam logic [15:0] SEL_IDLE = {3'd7, 3'd7, 3'd7, 3'd7, 2'd0, 2'd0};

  localparam logic [15:0] SEL_G0 [0:8] = '{
    {3'd0, 3'd0, 3'd7, 3'd7, 2'd0, 2'd0},
    {3'd1, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0},
    {3'd1, 3'd0, 3'd1, 3'd1, 2'd1, 2'd1},
    {3'd3, 3'd1, 3'd3, 3'd0, 2'd3, 2'd0},
    {3'd3, 3'd1, 3'd3, 3'd3, 2'd2, 2'd0},
    {3'd3, 3'd3, 3'd2, 3'd3, 2'd3, 2'd3},
    {3'd2, 3'd2, 3'd2, 3'd2, 2'd1, 2'd2},
    {3'd7, 3'd7, 3'd7, 3'd7, 2'd1, 2'd2},
    {3'd7, 3'd7, 3'd7, 3'd7, 2'd0, 2'd0}
  };

  localparam logic [15:0] SEL_G1 [0:8] = '{
    {3'd7, 3'd7, 3'd6, 3'd6, 2'd0, 2'd0},
    {3'd7, 3'd7, 3'd4, 3'd4, 2'd1, 2'd1},
    {3'd6, 3'd6, 3'd0, 3'd0, 2'd1, 2'd2},
    {3'd3, 3'd1, 3'd0, 3'd0, 2'd0, 2'd2},
    {3'd0, 3'd0, 3'd3, 3'd0, 2'd1, 2'd3},
    {3'd3, 3'd3, 3'd3, 3'd3, 2'd3, 2'd2},
    {3'd7, 3'd7, 3'd2, 3'd2, 2'd2, 2'd0},
    {3'd7, 3'd7, 3'd7, 3'd7, 2'd2, 2'd0},
    {3'd7, 3'd7, 3'd7, 3'd7, 2'd0, 2'd0}
  };

  localparam logic [15:0] SEL_G2 [0:8] = '{
    {3'd7, 3'd7, 3'd1, 3'd4, 2'd0, 2'd0},
    {3'd4, 3'd0, 3'd6, 3'd6, 2'd0, 2'd0},
    {3'd5, 3'd4, 3'd4, 3'd4, 2'd3, 2'd0},
    {3'd5, 3'd4, 3'd0, 3'd0, 2'd0, 2'd0},
    {3'd6, 3'd6, 3'd0, 3'd0, 2'd3, 2'd1},
    {3'd3, 3'd1, 3'd3, 3'd0, 2'd3, 2'd0},
    {3'd3, 3'd1, 3'd3, 3'd3, 2'd2, 2'd2},
    {3'd3, 3'd3, 3'd7, 3'd7, 2'd1, 2'd3},
    {3'd7, 3'd7, 3'd7, 3'd7, 2'd1, 2'd3}
  };

  state_t              state, state_nxt;
  logic [1:0]          pilot;
  logic                slot_one;
  logic                both_ready;
  logic [1:0]          v_grp;
  logic                seq_start;
  logic                seq_run;
  logic [1:0]          seq_wait;
  logic [STEP_W-1:0]   seq_step;
  logic [1:0]          seq_grp;
  logic                seq_on;
  logic [STEP_W-1:0]   last_step;
  logic [15:0]         sel_word;

  assign both_ready = demap_ready & NRS_gen_ready;

  always_comb begin
    case (v_shift)
      3'd1, 3'd4, 3'd7: v_grp = 2'd1;
      3'd2, 3'd5:       v_grp = 2'd2;
      default:          v_grp = 2'd0;
    endcase
  end

  assign s_est = (v_shift == 3'd1) || (v_shift == 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:                 if (both_ready) state_nxt = slot_one ? MULT_STORE : MULT_ADD;
      MULT_STORE, MULT_ADD: if (pilot == 2'd3) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    demap_read     = 1'b0;
    col            = 4'd0;
    nrs_index_addr = 2'd0;
    addr_mem       = 2'd0;
    case (state)
      MULT_STORE: begin
        demap_read     = 1'b1;
        col            = pilot[1] ? 4'd6 : 4'd5;
        nrs_index_addr = pilot;
        addr_mem       = pilot;
      end
      MULT_ADD: begin
        demap_read     = 1'b1;
        col            = pilot[1] ? 4'd13 : 4'd12;
        nrs_index_addr = pilot;
        addr_mem       = pilot;
      end
      default: ;
    endcase
  end

  // Enables trail demap_read by one cycle so each write lands after the product is formed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pilot       <= 2'd0;
      slot_one    <= 1'b1;
      rd_addr_nrs <= '0;
      mult_mem_en <= 1'b0;
      avg_mem_en  <= 1'b0;
    end else begin
      mult_mem_en <= demap_read && (state == MULT_STORE);
      avg_mem_en  <= demap_read && (state == MULT_ADD);
      if (state != IDLE) begin
        pilot       <= pilot + 2'd1;
        rd_addr_nrs <= rd_addr_nrs + NRS_ADDR'(2);
        if (pilot == 2'd3) slot_one <= ~slot_one;
      end
    end
  end

  assign seq_start = (state == IDLE) && (state_nxt == MULT_ADD);
  assign last_step = (seq_grp == 2'd2) ? STEP_W'(8) : STEP_W'(7);
  assign seq_on    = seq_run && (seq_wait == 2'd0);

  // Group 1 waits one cycle longer before step 0 than groups 0 and 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_run  <= 1'b0;
      seq_wait <= 2'd0;
      seq_step <= '0;
      seq_grp  <= 2'd0;
    end else if (seq_start) begin
      seq_run  <= 1'b1;
      seq_wait <= (v_grp == 2'd1) ? 2'd3 : 2'd2;
      seq_step <= '0;
      seq_grp  <= v_grp;
    end else if (seq_run) begin
      if (seq_wait != 2'd0) begin
        seq_wait <= seq_wait - 2'd1;
      end else if (seq_step == last_step) begin
        seq_run  <= 1'b0;
        seq_step <= '0;
      end else begin
        seq_step <= seq_step + STEP_W'(1);
      end
    end
  end

  always_comb begin
    sel_word   = SEL_IDLE;
    valid_eqlz = 1'b0;
    en_reg_E   = 1'b0;
    en_reg_2E  = 1'b0;
    en_reg_5E  = 1'b0;
    if (seq_on) begin
      case (seq_grp)
        2'd0: begin
          sel_word   = SEL_G0[seq_step];
          en_reg_E   = (seq_step == STEP_W'(1));
          en_reg_2E  = (seq_step == STEP_W'(2));
          en_reg_5E  = (seq_step == STEP_W'(6));
          valid_eqlz = (seq_step >= STEP_W'(2)) && (seq_step <= STEP_W'(6));
        end
        2'd1: begin
          sel_word   = SEL_G1[seq_step];
          en_reg_E   = (seq_step == STEP_W'(5));
          en_reg_2E  = (seq_step == STEP_W'(1));
          valid_eqlz = (seq_step >= STEP_W'(2)) && (seq_step <= STEP_W'(6));
        end
        2'd2: begin
          sel_word   = SEL_G2[seq_step];
          en_reg_E   = (seq_step == STEP_W'(2));
          en_reg_2E  = (seq_step == STEP_W'(2));
          en_reg_5E  = (seq_step == STEP_W'(1));
          valid_eqlz = (seq_step >= STEP_W'(3)) && (seq_step <= STEP_W'(7));
        end
        default: ;
      endcase
    end
    {s1a, s1b, s2a, s2b, s_h1, s_h2} = sel_word;
  end

`ifdef CH_EST_INTERP_DONE_EN
  assign interp_done = seq_on && (seq_step == last_step);
`endif

endmodule

// File: tb/tb_ch_est_cntrl_unit.sv
// Self-checking bench for ch_est_cntrl_unit: reset vector table plus scoreboarded store/add passes.
module tb_ch_est_cntrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       demap_ready = 1'b0;
  logic       NRS_gen_ready = 1'b0;
  logic [2:0] v_shift = 3'd0;
  logic [3:0] col;
  logic [1:0] nrs_index_addr;
  logic       demap_read;
  logic [3:0] rd_addr_nrs;
  logic       valid_eqlz;
  logic [1:0] addr_mem;
  logic       mult_mem_en, avg_mem_en;
  logic       en_reg_E, en_reg_2E, en_reg_5E;
  logic [2:0] s1a, s1b, s2a, s2b;
  logic [1:0] s_h1, s_h2;
  logic       s_est;

  always #5 clk = ~clk;

  ch_est_cntrl_unit #(.NRS_ADDR(4), .OUT_SEL_SEQ_LENGTH(12)) dut (
    .clk(clk), .rst(rst), .demap_ready(demap_ready), .NRS_gen_ready(NRS_gen_ready),
    .v_shift(v_shift), .col(col), .nrs_index_addr(nrs_index_addr), .demap_read(demap_read),
    .rd_addr_nrs(rd_addr_nrs), .valid_eqlz(valid_eqlz), .addr_mem(addr_mem),
    .mult_mem_en(mult_mem_en), .avg_mem_en(avg_mem_en), .en_reg_E(en_reg_E),
    .en_reg_2E(en_reg_2E), .en_reg_5E(en_reg_5E), .s1a(s1a), .s1b(s1b), .s2a(s2a),
    .s2b(s2b), .s_h1(s_h1), .s_h2(s_h2), .s_est(s_est)
  );

  typedef struct packed {
    logic       demap_read;
    logic [3:0] col;
    logic [1:0] nrs_index_addr;
    logic [1:0] addr_mem;
    logic [3:0] rd_addr_nrs;
    logic       mult_mem_en;
    logic       avg_mem_en;
    logic       valid_eqlz;
    logic       en_reg_E;
    logic       en_reg_2E;
    logic       en_reg_5E;
    logic [2:0] s1a;
    logic [2:0] s1b;
    logic [2:0] s2a;
    logic [2:0] s2b;
    logic [1:0] s_h1;
    logic [1:0] s_h2;
    logic       s_est;
  } out_rec_t;

  typedef struct {
    logic       dr;
    logic       nr;
    logic [2:0] vs;
  } rst_vec_t;

  int err_cnt = 0;
  int chk_cnt = 0;
  out_rec_t exp_q[$];

  int s1a_tab [3][9] = '{'{0,1,1,3,3,3,2,7,7}, '{7,7,6,3,0,3,7,7,7}, '{7,4,5,5,6,3,3,3,7}};
  int s1b_tab [3][9] = '{'{0,0,0,1,1,3,2,7,7}, '{7,7,6,1,0,3,7,7,7}, '{7,0,4,4,6,1,1,3,7}};
  int s2a_tab [3][9] = '{'{7,0,1,3,3,2,2,7,7}, '{6,4,0,0,3,3,2,7,7}, '{1,6,4,0,0,3,3,7,7}};
  int s2b_tab [3][9] = '{'{7,0,1,0,3,3,2,7,7}, '{6,4,0,0,0,3,2,7,7}, '{4,6,4,0,0,0,3,7,7}};
  int sh1_tab [3][9] = '{'{0,0,1,3,2,3,1,1,0}, '{0,1,1,0,1,3,2,2,0}, '{0,0,3,0,3,3,2,1,1}};
  int sh2_tab [3][9] = '{'{0,0,1,0,0,3,2,2,0}, '{0,1,2,2,3,2,0,0,0}, '{0,0,0,0,1,0,2,3,3}};
  int first_sample [3] = '{3, 4, 3};
  int seq_len      [3] = '{8, 8, 9};
  int e_step       [3] = '{1, 5, 2};
  int e2_step      [3] = '{2, 1, 2};
  int e5_step      [3] = '{6, -1, 1};
  int v_lo         [3] = '{2, 2, 3};
  int v_hi         [3] = '{6, 6, 7};

  function automatic out_rec_t reset_rec(input logic [2:0] vs);
    out_rec_t r;
    r       = '0;
    r.s1a   = 3'd7;
    r.s1b   = 3'd7;
    r.s2a   = 3'd7;
    r.s2b   = 3'd7;
    r.s_est = (vs == 3'd1) || (vs == 3'd4);
    return r;
  endfunction

  function automatic out_rec_t dut_rec();
    out_rec_t r;
    r.demap_read     = demap_read;
    r.col            = col;
    r.nrs_index_addr = nrs_index_addr;
    r.addr_mem       = addr_mem;
    r.rd_addr_nrs    = rd_addr_nrs;
    r.mult_mem_en    = mult_mem_en;
    r.avg_mem_en     = avg_mem_en;
    r.valid_eqlz     = valid_eqlz;
    r.en_reg_E       = en_reg_E;
    r.en_reg_2E      = en_reg_2E;
    r.en_reg_5E      = en_reg_5E;
    r.s1a            = s1a;
    r.s1b            = s1b;
    r.s2a            = s2a;
    r.s2b            = s2b;
    r.s_h1           = s_h1;
    r.s_h2           = s_h2;
    r.s_est          = s_est;
    return r;
  endfunction

  task automatic applyStimulus(input logic dr, input logic nr, input logic [2:0] vs);
    demap_ready   = dr;
    NRS_gen_ready = nr;
    v_shift       = vs;
  endtask

  task automatic checkOutput(input string name);
    out_rec_t e, a;
    e = exp_q.pop_front();
    a = dut_rec();
    chk_cnt++;
    if (a !== e) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // One pass from IDLE: readies raised, then NRS_gen_ready dropped so the FSM parks in IDLE afterwards.
  task automatic run_pass(input bit is_add, input logic [3:0] rd_base, input logic [2:0] vs,
                          input int n, input int rst_at, input string tag);
    out_rec_t e;
    int g;
    int s;
    g = int'(vs) % 3;
    for (int i = 1; i <= n; i++) begin
      e = reset_rec(vs);
      if (!(rst_at > 0 && i >= rst_at)) begin
        e.rd_addr_nrs = 4'(rd_base + 4'd8);
        if (i <= 4) begin
          e.demap_read     = 1'b1;
          e.nrs_index_addr = 2'(i - 1);
          e.addr_mem       = 2'(i - 1);
          e.rd_addr_nrs    = 4'(int'(rd_base) + 2 * (i - 1));
          if (is_add) e.col = (i <= 2) ? 4'd12 : 4'd13;
          else        e.col = (i <= 2) ? 4'd5 : 4'd6;
        end
        if (i >= 2 && i <= 5) begin
          if (is_add) e.avg_mem_en = 1'b1;
          else        e.mult_mem_en = 1'b1;
        end
        if (is_add) begin
          s = i - first_sample[g];
          if (s >= 0 && s < seq_len[g]) begin
            e.s1a        = 3'(s1a_tab[g][s]);
            e.s1b        = 3'(s1b_tab[g][s]);
            e.s2a        = 3'(s2a_tab[g][s]);
            e.s2b        = 3'(s2b_tab[g][s]);
            e.s_h1       = 2'(sh1_tab[g][s]);
            e.s_h2       = 2'(sh2_tab[g][s]);
            e.en_reg_E   = (s == e_step[g]);
            e.en_reg_2E  = (s == e2_step[g]);
            e.en_reg_5E  = (s == e5_step[g]);
            e.valid_eqlz = (s >= v_lo[g]) && (s <= v_hi[g]);
          end
        end
      end
      exp_q.push_back(e);
    end
    applyStimulus(1'b1, 1'b1, vs);
    for (int i = 1; i <= n; i++) begin
      if (i == rst_at) begin
        @(posedge clk);
        #2 rst = 1'b1;
      end
      @(negedge clk);
      checkOutput($sformatf("%s_s%0d", tag, i));
      if (i == 1) applyStimulus(1'b1, 1'b0, vs);
    end
  endtask

  initial begin
    rst_vec_t rv [6];
    rv = '{'{1'b0, 1'b0, 3'd0}, '{1'b1, 1'b1, 3'd0}, '{1'b1, 1'b0, 3'd1},
           '{1'b0, 1'b1, 3'd4}, '{1'b1, 1'b1, 3'd5}, '{1'b1, 1'b1, 3'd7}};
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(rv[i].dr, rv[i].nr, rv[i].vs);
      exp_q.push_back(reset_rec(rv[i].vs));
      repeat (2) @(negedge clk);
      checkOutput($sformatf("reset_vec%0d", i));
    end
    applyStimulus(1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_pass(1'b0, 4'd0, 3'd0, 15, 0, "store_v0");
    run_pass(1'b1, 4'd8, 3'd0, 14, 0, "add_v0");
    run_pass(1'b0, 4'd0, 3'd4, 6, 0, "store_v4");
    run_pass(1'b1, 4'd8, 3'd4, 14, 0, "add_v4");
    run_pass(1'b0, 4'd0, 3'd5, 6, 0, "store_v5");
    run_pass(1'b1, 4'd8, 3'd5, 8, 7, "add_v5_rst");

    applyStimulus(1'b0, 1'b0, 3'd5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_pass(1'b0, 4'd0, 3'd2, 6, 0, "store_v2");
    run_pass(1'b1, 4'd8, 3'd2, 14, 0, "add_v2");
    run_pass(1'b0, 4'd0, 3'd7, 6, 0, "store_v7");
    run_pass(1'b1, 4'd8, 3'd6, 14, 0, "add_v6");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ch_est_cntrl_unit.md
Name: ch_est_cntrl_unit

Overview:
- Control unit of the NB-IoT channel-estimation block.
- Sequences two NRS passes: slot 1 multiply-and-store, slot 2 multiply-and-average.
- Drives demapper and NRS-generator read addresses, internal memory enables, and the interpolation datapath selects/register enables.
- Signals valid estimates to the equalizer.

Parameters:
NRS_ADDR, 4, width of rd_addr_nrs.
OUT_SEL_SEQ_LENGTH, 12, upper bound on interpolation step count; the step counter is sized from it (≥9 required).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
demap_ready  in  1  demapper has pilot REs ready.
NRS_gen_ready  in  1  NRS sequence ready.
v_shift  in  3  NRS frequency shift 0..5.
col  out  4  symbol column read from demapper.
nrs_index_addr  out  2  pilot index within a pass.
demap_read  out  1  demapper read strobe.
rd_addr_nrs  out  NRS_ADDR  NRS generator read address.
valid_eqlz  out  1  estimate valid to equalizer.
addr_mem  out  2  internal pilot-memory address.
mult_mem_en  out  1  product-memory write enable, slot 1.
avg_mem_en  out  1  averaging-memory enable, slot 2.
en_reg_E, en_reg_2E, en_reg_5E  out  1 each  interpolation register loads.
s1a, s1b, s2a, s2b  out  3 each  adder-input mux selects.
s_h1, s_h2  out  2 each  output mux selects.
s_est  out  1  estimate mux select.

Behaviour:
- Reset values: all outputs 0, except s1a..s2b = 3'b111. Reset clears the FSM to IDLE, the slot flag to slot 1, rd_addr_nrs to 0 and aborts any interpolation sequence. Reset mid-operation behaves identically.
- FSM states: IDLE, MULT_STORE, MULT_ADD.
- IDLE: waits for demap_ready && NRS_gen_ready. Goes to MULT_STORE if the slot flag is 1, otherwise MULT_ADD.
- MULT_STORE and MULT_ADD each last exactly 4 cycles, pilot k = 0..3:
  - demap_read = 1; addr_mem = k; nrs_index_addr = k.
  - col = 5,5,6,6 in MULT_STORE and 12,12,13,13 in MULT_ADD.
  - rd_addr_nrs is registered. It advances by 2 per pilot, persists across passes and wraps modulo 2^NRS_ADDR. First pilot after reset reads 0; sequence is 0,2,4,6 then 8,10,12,14.
- Memory enables: demap_read delayed one cycle, routed to mult_mem_en in MULT_STORE or avg_mem_en in MULT_ADD. This makes the enable 0 on pilot 0, 1 on pilots 1..3, and 1 on the following cycle.
- End of pass: demap_read = 0 and the slot flag toggles. The next state is IDLE; if both readies are still high, IDLE is left on the next cycle.
- Interpolation start: entering MULT_ADD starts the sequencer, which runs independently of the FSM.
- v_shift grouping: g = v_shift mod 3; values 6 and 7 are treated as 0 and 1.
- Interpolation step 0 appears on the outputs in MULT_ADD cycle 3 (g = 0, 2) or cycle 4 (g = 1). Step count is 8 for g = 0, 1 and 9 for g = 2.
- s_est = 1 iff v_shift ∈ {1,4}, combinational, always driven.
- Select sequences per step (g0 | g1 | g2):
  - s1a: 0,1,1,3,3,3,2,7 | 7,7,6,3,0,3,7,7 | 7,4,5,5,6,3,3,3,7
  - s1b: 0,0,0,1,1,3,2,7 | 7,7,6,1,0,3,7,7 | 7,0,4,4,6,1,1,3,7
  - s2a: 7,0,1,3,3,2,2,7 | 6,4,0,0,3,3,2,7 | 1,6,4,0,0,3,3,7,7
  - s2b: 7,0,1,0,3,3,2,7 | 6,4,0,0,0,3,2,7 | 4,6,4,0,0,0,3,7,7
  - s_h1: 0,0,1,3,2,3,1,1 | 0,1,1,0,1,3,2,2 | 0,0,3,0,3,3,2,1,1
  - s_h2: 0,0,1,0,0,3,2,2 | 0,1,2,2,3,2,0,0 | 0,0,0,0,1,0,2,3,3
- Register loads, one-cycle pulses at the given step (g0 / g1 / g2):
  - en_reg_E: 1 / 5 / 2
  - en_reg_2E: 2 / 1 / 2
  - en_reg_5E: 6 / never / 1
- valid_eqlz = 1 on steps 2..6 (g0, g1) or steps 3..7 (g2); 0 otherwise.
- After the last step, selects return to their reset defaults.
- A new MULT_ADD while the sequencer is running restarts it.

Optional Feature:
- Macro: CH_EST_INTERP_DONE_EN.
- Defined: adds output interp_done (1 bit, reset 0), a one-cycle pulse coincident with the last interpolation step.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. rst = 1 held, any demap_ready/NRS_gen_ready/v_shift combination -> all outputs stay at reset values (s1a..s2b = 7, others 0).
2. From reset, demap_ready = NRS_gen_ready = 1 -> 4 cycles with demap_read = 1, addr_mem/nrs_index_addr 0..3, col 5,5,6,6, rd_addr_nrs 0,2,4,6; mult_mem_en 0,1,1,1.
3. Drop NRS_gen_ready for 10 cycles, then raise it -> FSM holds IDLE; then MULT_ADD with col 12,12,13,13, rd_addr_nrs 8..14, avg_mem_en 0,1,1,1.
4. v_shift = 0 full run -> step 0 in MULT_ADD cycle 3; s1a sequence 0,1,1,3,3,3,2,7; valid_eqlz on steps 2..6; en_reg_5E at step 6.
5. v_shift = 4 -> s_est = 1; step 0 in MULT_ADD cycle 4; en_reg_2E at step 1, en_reg_E at step 5.
6. v_shift = 5 -> 9 steps; valid_eqlz on steps 3..7; en_reg_E and en_reg_2E both at step 2; assert rst at step 4 -> all outputs at reset defaults immediately.
